even_pipe_issue_scoreboard: RTL and testbench

- Issue controller in front of the even pipe (`evenpipe`).
- Accepts one decoded instruction per cycle over a valid/ready handshake.
- Tracks pending register writes with per-register countdown counters.
- Stalls issue on RAW/WAW hazards and on even-pipe writeback-port collisions; forwards accepted instructions one cycle later.

---
 rtl/even_pipe_issue_scoreboard_if.sv | 39 +++
 rtl/even_pipe_issue_scoreboard.sv | 118 +++++++++++
 tb/tb_even_pipe_issue_scoreboard.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/even_pipe_issue_scoreboard_if.sv
// Opcode package and the issue handshake interface between the decoder and the even-pipe scoreboard.
package epis_pkg;
  typedef enum logic [4:0] {
    OP_NOP,
    OP_ADD_WORD,
    OP_AND,
    OP_OR,
    OP_MULTIPLY,
    OP_FLOATING_MULTIPLY
  } opcode_e;
endpackage

interface even_pipe_issue_scoreboard_if #(parameter int AW = 7, parameter int LAT_W = 3);
  import epis_pkg::*;
  logic             in_valid;
  logic             in_ready;
  opcode_e          in_op_code;
  logic [AW-1:0]    in_ra, in_rb, in_rc, in_rt;
  logic             in_use_ra, in_use_rb, in_use_rc;
  logic             in_wr_en;
  logic [LAT_W-1:0] in_latency;
  logic             issue_valid;
  opcode_e          issue_op_code;
  logic [AW-1:0]    issue_ra, issue_rb, issue_rc, issue_rt;
  logic             issue_wr_en;

  modport master (
    output in_valid, in_op_code, in_ra, in_rb, in_rc, in_rt,
           in_use_ra, in_use_rb, in_use_rc, in_wr_en, in_latency,
    input  in_ready,
    input  issue_valid, issue_op_code, issue_ra, issue_rb, issue_rc, issue_rt, issue_wr_en
  );
  modport slave (
    input  in_valid, in_op_code, in_ra, in_rb, in_rc, in_rt,
           in_use_ra, in_use_rb, in_use_rc, in_wr_en, in_latency,
    output in_ready,
    output issue_valid, issue_op_code, issue_ra, issue_rb, issue_rc, issue_rt, issue_wr_en
  );
endinterface

// File: rtl/even_pipe_issue_scoreboard.sv
// Even-pipe issue scoreboard: per-register writeback countdowns, RAW/WAW/port hazard stall, 1-cycle issue.
module epis_reg_cnt #(
  parameter int LAT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             set,
  input  logic [LAT_W-1:0] leff,
  output logic             busy
);
  logic [LAT_W-1:0] cnt;

  // A new reservation overrides the running decrement
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)            cnt <= '0;
    else if (flush)        cnt <= '0;
    else if (set)          cnt <= leff;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0);
endmodule

module even_pipe_issue_scoreboard
  import epis_pkg::*;
#(
  parameter int NUM_REGS = 128,
  parameter int MAX_LAT  = 7,
  parameter int LAT_W    = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  even_pipe_issue_scoreboard_if.slave bus,
  output logic [NUM_REGS-1:0]         reg_busy,
  output logic [15:0]                 stall_count
);
  localparam int SW = MAX_LAT + 2;

  logic [LAT_W-1:0]    leff;
  logic [LAT_W:0]      pslot;
  logic [MAX_LAT:1]    wb_slot, wb_nxt;
  logic [SW-1:0]       wb_ext;
  logic [NUM_REGS-1:0] set_vec;
  logic                raw_hz, waw_hz, port_hz, hazard, accept;

  assign leff  = (bus.in_latency < LAT_W'(2)) ? LAT_W'(2) : bus.in_latency;
  assign pslot = {1'b0, leff} + (LAT_W+1)'(1);
  // Zero-padded at both ends so slot MAX_LAT+1 reads as free
  assign wb_ext = {1'b0, wb_slot, 1'b0};

  assign raw_hz  = (bus.in_use_ra & reg_busy[bus.in_ra]) |
                   (bus.in_use_rb & reg_busy[bus.in_rb]) |
                   (bus.in_use_rc & reg_busy[bus.in_rc]);
  assign waw_hz  = bus.in_wr_en & reg_busy[bus.in_rt];
  assign port_hz = bus.in_wr_en & wb_ext[pslot];
  assign hazard  = raw_hz | waw_hz | port_hz;

  assign bus.in_ready = reset & ~hazard & ~flush;
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    set_vec = '0;
    if (accept && bus.in_wr_en) set_vec[bus.in_rt] = 1'b1;
  end

  always_comb begin
    wb_nxt = {1'b0, wb_slot[MAX_LAT:2]};
    if (accept && bus.in_wr_en) wb_nxt[leff] = 1'b1;
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    epis_reg_cnt #(.LAT_W(LAT_W)) u_cnt (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .set   (set_vec[r]),
      .leff  (leff),
      .busy  (reg_busy[r])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     wb_slot <= '0;
    else if (flush) wb_slot <= '0;
    else            wb_slot <= wb_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.issue_valid   <= 1'b0;
      bus.issue_op_code <= OP_NOP;
      bus.issue_ra      <= '0;
      bus.issue_rb      <= '0;
      bus.issue_rc      <= '0;
      bus.issue_rt      <= '0;
      bus.issue_wr_en   <= 1'b0;
    end else begin
      bus.issue_valid <= accept;
      if (accept) begin
        bus.issue_op_code <= bus.in_op_code;
        bus.issue_ra      <= bus.in_ra;
        bus.issue_rb      <= bus.in_rb;
        bus.issue_rc      <= bus.in_rc;
        bus.issue_rt      <= bus.in_rt;
        bus.issue_wr_en   <= bus.in_wr_en;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      stall_count <= '0;
    else if (bus.in_valid && !bus.in_ready && !flush && stall_count != 16'hFFFF)
      stall_count <= stall_count + 16'd1;
  end
endmodule

// File: tb/tb_even_pipe_issue_scoreboard.sv
// Directed bench for even_pipe_issue_scoreboard; issued instructions are checked by a queue-based monitor.
module tb_even_pipe_issue_scoreboard;
  import epis_pkg::*;

  typedef struct packed {
    opcode_e    op;
    logic [6:0] ra, rb, rc, rt;
    logic       wr;
  } iss_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         flush;
  logic [127:0] reg_busy;
  logic [15:0]  stall_count;
  int           total = 0;
  int           bad   = 0;
  int           s;
  iss_t         sb[$];

  even_pipe_issue_scoreboard_if #(.AW(7), .LAT_W(3)) ifc();

  even_pipe_issue_scoreboard #(.NUM_REGS(128), .MAX_LAT(7), .LAT_W(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .bus         (ifc),
    .reg_busy    (reg_busy),
    .stall_count (stall_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Offer one instruction and hold it until accepted; returns the stalled cycles
  task automatic send(input opcode_e op, input logic [6:0] ra, rb, rc, rt,
                      input logic ura, urb, urc, wr, input logic [2:0] lat,
                      output int stalls);
    iss_t e;
    bit   ok = 0;
    ifc.in_op_code = op;  ifc.in_ra = ra; ifc.in_rb = rb; ifc.in_rc = rc; ifc.in_rt = rt;
    ifc.in_use_ra = ura;  ifc.in_use_rb = urb; ifc.in_use_rc = urc;
    ifc.in_wr_en = wr;    ifc.in_latency = lat; ifc.in_valid = 1'b1;
    stalls = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (ifc.in_ready === 1'b1) begin
        e.op = op; e.ra = ra; e.rb = rb; e.rc = rc; e.rt = rt; e.wr = wr;
        sb.push_back(e);
        ok = 1;
        break;
      end
      stalls++;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout rt=%0d act=not_accepted exp=accepted", rt);
    end
    @(posedge clock); #1;
    ifc.in_valid = 1'b0;
  endtask

  always @(negedge clock) begin
    if (reset === 1'b1 && ifc.issue_valid === 1'b1) begin
      iss_t a, e;
      a.op = ifc.issue_op_code; a.ra = ifc.issue_ra; a.rb = ifc.issue_rb;
      a.rc = ifc.issue_rc; a.rt = ifc.issue_rt; a.wr = ifc.issue_wr_en;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected act=%h exp=none", a);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL issue_fields act=%h exp=%h", a, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; flush = 1'b0;
    ifc.in_valid = 1'b0; ifc.in_op_code = OP_NOP;
    ifc.in_ra = '0; ifc.in_rb = '0; ifc.in_rc = '0; ifc.in_rt = '0;
    ifc.in_use_ra = 1'b0; ifc.in_use_rb = 1'b0; ifc.in_use_rc = 1'b0;
    ifc.in_wr_en = 1'b0; ifc.in_latency = '0;
    #2;
    chk("rst_busy", 32'(|reg_busy), 0);
    chk("rst_issue_valid", 32'(ifc.issue_valid), 0);
    chk("rst_stall_count", 32'(stall_count), 0);
    chk("rst_in_ready", 32'(ifc.in_ready), 0);
    idle(2);
    reset = 1'b1;
    idle(1);

    // Back-to-back independent adds
    send(OP_ADD_WORD, 1, 2, 0, 3, 1, 1, 0, 1, 2, s); chk("b2b_stall_a", s, 0);
    send(OP_ADD_WORD, 5, 6, 0, 4, 1, 1, 0, 1, 2, s); chk("b2b_stall_b", s, 0);
    @(negedge clock); chk("b2b_stall_count", 32'(stall_count), 0);
    idle(4);

    // RAW on r10
    send(OP_FLOATING_MULTIPLY, 0, 0, 0, 10, 0, 0, 0, 1, 6, s); chk("raw_stall_prod", s, 0);
    send(OP_AND, 10, 0, 0, 11, 1, 0, 0, 1, 2, s);              chk("raw_stalls", s, 6);
    @(negedge clock); chk("raw_stall_count", 32'(stall_count), 6);
    idle(4);

    // WAW on r7
    send(OP_MULTIPLY, 0, 0, 0, 7, 0, 0, 0, 1, 7, s); chk("waw_stall_prod", s, 0);
    send(OP_OR, 0, 0, 0, 7, 0, 0, 0, 1, 2, s);       chk("waw_stalls", s, 7);
    @(negedge clock); chk("waw_stall_count", 32'(stall_count), 13);
    idle(4);

    // Writeback port collision: A(L4) at t, B(L3) offered at t+1
    send(OP_ADD_WORD, 0, 0, 0, 20, 0, 0, 0, 1, 4, s); chk("port_stall_a", s, 0);
    send(OP_ADD_WORD, 0, 0, 0, 21, 0, 0, 0, 1, 3, s); chk("port_stalls_b", s, 1);
    @(negedge clock); chk("port_t3_a", 32'(reg_busy[20]), 1); chk("port_t3_b", 32'(reg_busy[21]), 1);
    idle(1); @(negedge clock); chk("port_t4_a", 32'(reg_busy[20]), 1);
    idle(1); @(negedge clock); chk("port_t5_a", 32'(reg_busy[20]), 0); chk("port_t5_b", 32'(reg_busy[21]), 1);
    idle(1); @(negedge clock); chk("port_t6_b", 32'(reg_busy[21]), 0);
    chk("port_stall_count", 32'(stall_count), 14);
    idle(4);

    // Flush clears the r30 reservation; dependent offered during flush is held off
    send(OP_FLOATING_MULTIPLY, 0, 0, 0, 30, 0, 0, 0, 1, 7, s);
    idle(1);
    flush = 1'b1;
    ifc.in_op_code = OP_ADD_WORD; ifc.in_ra = 30; ifc.in_use_ra = 1'b1; ifc.in_rt = 31;
    ifc.in_wr_en = 1'b1; ifc.in_latency = 3'd2; ifc.in_valid = 1'b1;
    @(negedge clock);
    chk("flush_in_ready", 32'(ifc.in_ready), 0);
    chk("flush_busy_before", 32'(reg_busy[30]), 1);
    @(posedge clock); #1;
    flush = 1'b0;
    chk("flush_busy_after", 32'(|reg_busy), 0);
    send(OP_ADD_WORD, 30, 0, 0, 31, 1, 0, 0, 1, 2, s); chk("flush_dep_stalls", s, 0);
    chk("flush_stall_count", 32'(stall_count), 14);
    idle(4);

    // Latency 0 clamps to 2
    send(OP_OR, 0, 0, 0, 40, 0, 0, 0, 1, 0, s);
    @(negedge clock); chk("lat0_t1", 32'(reg_busy[40]), 1);
    idle(1); @(negedge clock); chk("lat0_t2", 32'(reg_busy[40]), 1);
    idle(1); @(negedge clock); chk("lat0_t3", 32'(reg_busy[40]), 0);
    idle(2);

    // Asynchronous reset with a reservation in flight
    send(OP_MULTIPLY, 0, 0, 0, 50, 0, 0, 0, 1, 7, s);
    chk("mid_pre_issue", 32'(ifc.issue_valid), 1);
    chk("mid_pre_busy", 32'(reg_busy[50]), 1);
    ifc.in_valid = 1'b1; ifc.in_use_ra = 1'b0; ifc.in_wr_en = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(|reg_busy), 0);
    chk("mid_rst_issue_valid", 32'(ifc.issue_valid), 0);
    chk("mid_rst_stall_count", 32'(stall_count), 0);
    chk("mid_rst_in_ready", 32'(ifc.in_ready), 0);
    sb.delete();
    ifc.in_valid = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);
    send(OP_ADD_WORD, 50, 0, 0, 50, 1, 0, 0, 1, 2, s); chk("post_rst_stalls", s, 0);
    idle(3);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
